// File: rtl/hazard_tracker_pkg.sv
// hazard_tracker_pkg: shared pipeline constants and per-stage control type
package hazard_tracker_pkg;

    localparam int REG_W = 4;
    localparam logic [REG_W-1:0] PC_IDX = '1;

    typedef struct packed {
        logic reg_write;
        logic memto_reg;
        logic pc_src;
    } stage_ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear priority
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && count != '1)
            count <= count + 1'b1;

endmodule

// File: rtl/hazard_tracker.sv
// hazard_tracker: E/M/W register tracking, forwarding matches and stall/flush counters
module hazard_tracker #(
    parameter int REG_W = hazard_tracker_pkg::REG_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [REG_W-1:0] RA1D,
    input  logic [REG_W-1:0] RA2D,
    input  logic [REG_W-1:0] WA3D,
    input  logic             RegWriteD,
    input  logic             MemtoRegD,
    input  logic             PCSrcD,
    input  logic             CondExE,
    input  logic             StallD,
    input  logic             FlushE,
    input  logic             cnt_clr,
    output logic             Match_1E_M,
    output logic             Match_2E_M,
    output logic             Match_1E_W,
    output logic             Match_2E_W,
    output logic             Match_12D_E,
    output logic             MemtoRegE,
    output logic             RegWriteM,
    output logic             RegWriteW,
    output logic             PCSrcW,
    output logic             PCWrPendingF,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    import hazard_tracker_pkg::*;

    localparam logic [REG_W-1:0] PC = {REG_W{1'b1}};

    logic [REG_W-1:0] ra1_e, ra2_e, wa3_e, wa3_m, wa3_w;
    stage_ctrl_t      ctl_e;
    logic             rw_m, pcs_m, rw_w, pcs_w;

    // M/W only carry what later stages observe; condition gating happens on E->M
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ra1_e <= '0;
            ra2_e <= '0;
            wa3_e <= '0;
            ctl_e <= '0;
            wa3_m <= '0;
            rw_m  <= 1'b0;
            pcs_m <= 1'b0;
            wa3_w <= '0;
            rw_w  <= 1'b0;
            pcs_w <= 1'b0;
        end else begin
            ra1_e <= FlushE ? '0 : RA1D;
            ra2_e <= FlushE ? '0 : RA2D;
            wa3_e <= FlushE ? '0 : WA3D;
            ctl_e <= FlushE ? '0 : stage_ctrl_t'{RegWriteD, MemtoRegD, PCSrcD};
            wa3_m <= wa3_e;
            rw_m  <= ctl_e.reg_write & CondExE;
            pcs_m <= ctl_e.pc_src & CondExE;
            wa3_w <= wa3_m;
            rw_w  <= rw_m;
            pcs_w <= pcs_m;
        end

    assign Match_1E_M   = ra1_e != PC && ra1_e == wa3_m;
    assign Match_2E_M   = ra2_e != PC && ra2_e == wa3_m;
    assign Match_1E_W   = ra1_e != PC && ra1_e == wa3_w;
    assign Match_2E_W   = ra2_e != PC && ra2_e == wa3_w;
    assign Match_12D_E  = (RA1D != PC && RA1D == wa3_e) || (RA2D != PC && RA2D == wa3_e);
    assign MemtoRegE    = ctl_e.memto_reg;
    assign RegWriteM    = rw_m;
    assign RegWriteW    = rw_w;
    assign PCSrcW       = pcs_w;
    assign PCWrPendingF = PCSrcD | ctl_e.pc_src | pcs_m;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (StallD),
        .clr   (cnt_clr),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (FlushE),
        .clr   (cnt_clr),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_tracker.sv
// tb_hazard_tracker: random and directed checks against an instruction-record pipeline model
module tb_hazard_tracker;
    localparam int RW   = 4;
    localparam int CW   = 16;
    localparam int CMAX = 65535;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [RW-1:0] RA1D = '0, RA2D = '0, WA3D = '0;
    logic          RegWriteD = 0, MemtoRegD = 0, PCSrcD = 0;
    logic          CondExE = 1, StallD = 0, FlushE = 0, cnt_clr = 0;
    logic          Match_1E_M, Match_2E_M, Match_1E_W, Match_2E_W, Match_12D_E;
    logic          MemtoRegE, RegWriteM, RegWriteW, PCSrcW, PCWrPendingF;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int n_tests = 0;
    int n_fail = 0;

    typedef struct {
        int ra1, ra2, wa3;
        bit rw, mr, pcs;
    } ins_t;

    ins_t pipe [3];
    int   sc, fc;

    hazard_tracker #(.REG_W(RW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
        .RegWriteD(RegWriteD), .MemtoRegD(MemtoRegD), .PCSrcD(PCSrcD),
        .CondExE(CondExE), .StallD(StallD), .FlushE(FlushE), .cnt_clr(cnt_clr),
        .Match_1E_M(Match_1E_M), .Match_2E_M(Match_2E_M),
        .Match_1E_W(Match_1E_W), .Match_2E_W(Match_2E_W), .Match_12D_E(Match_12D_E),
        .MemtoRegE(MemtoRegE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .PCSrcW(PCSrcW), .PCWrPendingF(PCWrPendingF),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit fm(input int src, input int dst);
        return src != 15 && src == dst;
    endfunction

    task automatic model_reset();
        foreach (pipe[i]) pipe[i] = '{default: 0};
        sc = 0;
        fc = 0;
    endtask

    // instruction records age through E(0), M(1), W(2); a failed condition kills the record's effects
    task automatic model_step();
        if (!rst_n) return;
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        if (!CondExE) begin
            pipe[1].rw = 0;
            pipe[1].mr = 0;
            pipe[1].pcs = 0;
        end
        if (FlushE) pipe[0] = '{default: 0};
        else pipe[0] = '{int'(RA1D), int'(RA2D), int'(WA3D), RegWriteD, MemtoRegD, PCSrcD};
        sc = cnt_clr ? 0 : (StallD && sc < CMAX) ? sc + 1 : sc;
        fc = cnt_clr ? 0 : (FlushE && fc < CMAX) ? fc + 1 : fc;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set(input int a1, input int a2, input int w3, input bit rw, input bit mr, input bit pcs);
        RA1D = RW'(a1);
        RA2D = RW'(a2);
        WA3D = RW'(w3);
        RegWriteD = rw;
        MemtoRegD = mr;
        PCSrcD = pcs;
        #1;
    endtask

    task automatic rnd();
        RA1D = ($urandom_range(0, 3) == 0) ? 4'hF : RW'($urandom_range(0, 7));
        RA2D = ($urandom_range(0, 3) == 0) ? 4'hF : RW'($urandom_range(0, 7));
        WA3D = ($urandom_range(0, 3) == 0) ? 4'hF : RW'($urandom_range(0, 7));
        RegWriteD = 1'($urandom_range(0, 1));
        MemtoRegD = 1'($urandom_range(0, 1));
        PCSrcD = ($urandom_range(0, 5) == 0);
        CondExE = ($urandom_range(0, 3) != 0);
        StallD = ($urandom_range(0, 3) == 0);
        FlushE = ($urandom_range(0, 3) == 0);
        cnt_clr = ($urandom_range(0, 63) == 0);
    endtask

    always @(negedge clk) begin
        cmp("match_1e_m", Match_1E_M, fm(pipe[0].ra1, pipe[1].wa3));
        cmp("match_2e_m", Match_2E_M, fm(pipe[0].ra2, pipe[1].wa3));
        cmp("match_1e_w", Match_1E_W, fm(pipe[0].ra1, pipe[2].wa3));
        cmp("match_2e_w", Match_2E_W, fm(pipe[0].ra2, pipe[2].wa3));
        cmp("match_12d_e", Match_12D_E, fm(RA1D, pipe[0].wa3) | fm(RA2D, pipe[0].wa3));
        cmp("memtoreg_e", MemtoRegE, pipe[0].mr);
        cmp("regwrite_m", RegWriteM, pipe[1].rw);
        cmp("regwrite_w", RegWriteW, pipe[2].rw);
        cmp("pcsrc_w", PCSrcW, pipe[2].pcs);
        cmp("pcwr_pending", PCWrPendingF, PCSrcD | pipe[0].pcs | pipe[1].pcs);
        cmp("stall_cnt", stall_cnt, sc);
        cmp("flush_cnt", flush_cnt, fc);
    end

    initial begin
        model_reset();
        #2;
        cmp("rst_match_1e_m", Match_1E_M, 1);
        cmp("rst_match_12d_e", Match_12D_E, 1);
        cmp("rst_regwrite_m", RegWriteM, 0);
        cmp("rst_pcwr", PCWrPendingF, 0);
        cmp("rst_stall_cnt", stall_cnt, 0);
        #10 rst_n = 1'b1;
        tick();

        set(1, 2, 3, 1, 0, 0);
        tick();
        set(3, 4, 6, 1, 0, 0);
        tick();
        cmp("add_fwd_match", Match_1E_M, 1);
        cmp("add_fwd_regwrite_m", RegWriteM, 1);

        set(7, 8, 5, 1, 1, 0);
        tick();
        set(9, 5, 10, 1, 0, 0);
        cmp("ldr_use_match", Match_12D_E, 1);
        cmp("ldr_memtoreg_e", MemtoRegE, 1);
        StallD = 1;
        FlushE = 1;
        tick();
        cmp("bubble_memtoreg_e", MemtoRegE, 0);
        cmp("ldr_regwrite_m", RegWriteM, 1);
        StallD = 0;
        FlushE = 0;
        tick();
        cmp("bubble_regwrite_m", RegWriteM, 0);

        set(0, 0, 15, 1, 0, 1);
        cmp("pc_pend_d", PCWrPendingF, 1);
        tick();
        set(0, 0, 0, 0, 0, 0);
        cmp("pc_pend_e", PCWrPendingF, 1);
        tick();
        cmp("pc_pend_m", PCWrPendingF, 1);
        tick();
        cmp("pc_pend_done", PCWrPendingF, 0);
        cmp("pcsrc_w_set", PCSrcW, 1);
        tick();
        cmp("pcsrc_w_one", PCSrcW, 0);

        CondExE = 0;
        set(0, 0, 15, 1, 0, 1);
        tick();
        set(0, 0, 0, 0, 0, 0);
        cmp("nc_pend_e", PCWrPendingF, 1);
        tick();
        cmp("nc_pend_m", PCWrPendingF, 0);
        tick();
        cmp("nc_pcsrc_w", PCSrcW, 0);
        CondExE = 1;

        set(0, 0, 15, 1, 0, 0);
        tick();
        set(15, 15, 1, 0, 0, 0);
        tick();
        cmp("r15_match_1e_m", Match_1E_M, 0);
        cmp("r15_match_2e_m", Match_2E_M, 0);

        for (int i = 0; i < 3000; i++) begin
            rnd();
            if (i == 1500) begin
                repeat (3) begin
                    set(1, 2, 15, 1, 0, 1);
                    CondExE = 1;
                    FlushE = 0;
                    tick();
                end
                cmp("pre_rst_regwrite_m", RegWriteM, 1);
                cmp("pre_rst_pcsrc_w", PCSrcW, 1);
                PCSrcD = 0;
                #2 rst_n = 1'b0;
                model_reset();
                #1;
                cmp("arst_regwrite_m", RegWriteM, 0);
                cmp("arst_regwrite_w", RegWriteW, 0);
                cmp("arst_pcsrc_w", PCSrcW, 0);
                cmp("arst_pcwr", PCWrPendingF, 0);
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
            tick();
        end

        set(0, 0, 0, 0, 0, 0);
        CondExE = 1;
        FlushE = 0;
        cnt_clr = 0;
        StallD = 1;
        repeat (70000) tick();
        cmp("stall_saturate", stall_cnt, 16'hFFFF);
        cnt_clr = 1;
        tick();
        cmp("stall_clear", stall_cnt, 0);
        cnt_clr = 0;
        StallD = 0;
        tick();
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_tracker.md
HAZARD_TRACKER -- requirements
Module: hazard_tracker

Interface
REQ-001 SHALL have parameter REG_W, default 4, meaning register-address width.
REQ-002 SHALL have parameter CNT_W, default 16, meaning performance-counter width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have inputs RA1D, RA2D, WA3D, each REG_W wide: decode-stage source and destination register addresses.
REQ-006 SHALL have inputs RegWriteD, MemtoRegD, PCSrcD, each 1 bit: decode-stage control (PCSrcD means the instruction writes R15).
REQ-007 SHALL have input CondExE, 1 bit: execute-stage condition passed.
REQ-008 SHALL have inputs StallD, FlushE, 1 bit each, returned from the hazard unit.
REQ-009 SHALL have input cnt_clr, 1 bit: synchronous clear of both counters.
REQ-010 SHALL have outputs Match_1E_M, Match_2E_M, Match_1E_W, Match_2E_W, Match_12D_E, 1 bit each.
REQ-011 SHALL have outputs MemtoRegE, RegWriteM, RegWriteW, PCSrcW, PCWrPendingF, 1 bit each.
REQ-012 SHALL have outputs stall_cnt, flush_cnt, each CNT_W wide.

Function
REQ-013 SHALL hold E, M and W stage registers: RA1, RA2, WA3, RegWrite, MemtoReg, PCSrc.
REQ-014 D->E: each cycle the E registers load the D inputs; when FlushE=1 all E fields load 0 (bubble); FlushE overrides.
REQ-015 E->M: the M registers load the E fields every cycle; RegWrite, MemtoReg and PCSrc are ANDed with CondExE.
REQ-016 M->W: the W registers load the M fields every cycle; M and W never stall.
REQ-017 StallD SHALL NOT hold the E registers; on a load-use stall the bubble comes from FlushE.
REQ-018 Match_1E_M = (RA1E==WA3M), Match_2E_M = (RA2E==WA3M), Match_1E_W = (RA1E==WA3W), Match_2E_W = (RA2E==WA3W); all combinational from registers.
REQ-019 Match_12D_E = (RA1D==WA3E) | (RA2D==WA3E); combinational from the D inputs.
REQ-020 Any match SHALL be forced 0 when its source address equals all-ones (R15; the PC is never forwarded).
REQ-021 Outputs MemtoRegE, RegWriteM, RegWriteW and PCSrcW SHALL equal the corresponding stage registers.
REQ-022 PCWrPendingF = PCSrcD | PCSrcE | PCSrcM (M value already condition-gated).
REQ-023 stall_cnt SHALL increment when StallD=1; flush_cnt SHALL increment when FlushE=1.
REQ-024 Both counters saturate at all-ones with no wrap.
REQ-025 cnt_clr=1 zeroes both counters next edge and takes priority over increment.
REQ-026 No combinational path from StallD or FlushE to any output.

Reset
REQ-027 rst_n=0 SHALL asynchronously clear all stage registers and counters to 0.
REQ-028 During reset: all Match outputs follow the REG_W==0 comparisons (Match_12D_E may be 1 from D inputs); all control outputs and counters are 0.
REQ-029 Reset deassertion mid-pipeline SHALL leave only bubbles: no stale RegWrite or PCSrc survives.

Structure
REQ-030 REG_W, the PC index constant (all-ones), and a stage_ctrl_t struct (RegWrite, MemtoReg, PCSrc) SHALL live in the shared pipeline package.
REQ-031 One sub-module, sat_counter (CNT_W, inc, clr), instantiated twice.

Verification
REQ-032 ADD R3 in D, then ADD using R3 as RA1 next -> one cycle later Match_1E_M=1 and RegWriteM=1.
REQ-033 LDR R5 (MemtoRegD=1), then a D instruction reading RA2D=5 -> Match_12D_E=1 and MemtoRegE=1; FlushE=1 gives a bubble, so RegWriteM=0 next cycle.
REQ-034 A write to R15 with CondExE=1 -> PCWrPendingF=1 for 3 cycles (D,E,M), then PCSrcW=1 for 1 cycle; with CondExE=0, PCSrcW stays 0.
REQ-035 RA1E=15 and WA3M=15 -> Match_1E_M=0.
REQ-036 StallD held 1 for 70000 cycles with CNT_W=16 -> stall_cnt=16'hFFFF; cnt_clr together with StallD -> 0.
REQ-037 rst_n pulled low mid-stream, asynchronously to clk -> RegWriteM, RegWriteW, PCSrcW and PCWrPendingF (with PCSrcD=0) go to 0 immediately.
